hub75_row_driver: RTL
=====================

Name: hub75_row_driver

Overview:
- Drives one row pair of a HUB-75 panel from the 64-pixel x 2-bank line buffer.
- On start, it shifts 64 columns per bit plane, LSB plane first. It latches each plane and holds output-enable for a binary-weighted time (binary code modulation).
- Sits downstream of the line buffer and replaces the dummy driver under the row-sequencing controller (start / is_idle handshake).

Parameters:
- column_count, 64, pixels per row shifted per plane.
- color_depth, 8, bits per colour channel; number of bit planes.
- address_width, 7, line buffer read address width; MSB = bank, low 6 bits = column.
- data_width, 48, line buffer word: {upper R,G,B, lower R,G,B}, 8 bits each.
- row_width, 5, row address width (32 row pairs).
- base_on_time, 4, hub_oe_n low cycles for plane 0; plane b lasts base_on_time<<b.
- display_count_width, 10, must hold base_on_time<<(color_depth-1).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request; accepted only while is_idle=1.
- y  in  row_width  row pair to display; captured on accepted start.
- bank  in  1  line buffer bank to read; captured on accepted start.
- is_idle  out  1  high when no row is in progress.
- read_address  out  address_width  line buffer read address.
- read_data  in  data_width  line buffer data, valid one cycle after address.
- hub_r0, hub_g0, hub_b0  out  1 each  upper-half colour bits.
- hub_r1, hub_g1, hub_b1  out  1 each  lower-half colour bits.
- hub_clk  out  1  panel shift clock; panel samples on rising edge.
- hub_lat  out  1  panel latch strobe.
- hub_oe_n  out  1  panel output enable, active low.
- hub_addr  out  row_width  panel row address.

Behaviour:
- All outputs are registered. Reset (reset=0 at an edge) sets:
  - state kIdle, is_idle=1;
  - hub_oe_n=1, hub_lat=0, hub_clk=0;
  - all colour outputs 0, hub_addr=0, read_address=0;
  - plane and column counters 0.
- Reset mid-operation aborts immediately and discards the row: hub_oe_n=1 on the next edge.
- Word layout per column: upper R=[47:40], G=[39:32], B=[31:24]; lower R=[23:16], G=[15:8], B=[7:0]. Plane b drives bit b of each channel.
- kIdle:
  - is_idle=1, hub_oe_n=1.
  - start=1 captures y and bank, clears plane to 0, and goes to kFetch.
  - start while not in kIdle is ignored.
- kFetch (1 cycle): read_address={bank,0}; column=0; goes to kShiftLow.
- kShiftLow(x):
  - On entry, colour regs load plane bit of read_data (column x) and hub_clk=0.
  - read_address={bank,x+1}; for x=63 the address is don't-care.
  - Goes to kShiftHigh.
- kShiftHigh(x):
  - hub_clk=1; colour outputs held.
  - If x=63, go to kLatch; else column=x+1 and go to kShiftLow.
- kLatch (1 cycle): hub_lat=1, hub_oe_n=1, hub_clk=0; hub_addr loads captured y. Display count loads base_on_time<<plane.
- kDisplay:
  - hub_lat=0, hub_oe_n=0 for exactly base_on_time<<plane cycles.
  - Then hub_oe_n=1 on the following edge.
  - If plane=color_depth-1, go to kIdle (is_idle=1 on the same edge); else plane+1 and go to kFetch.
- No overlap of display and shift in this revision: hub_oe_n=1 throughout fetch/shift/latch.
- Cycles per plane = 130 + (base_on_time<<b). With defaults the row totals 8*130 + 4*255 = 2060 cycles: is_idle rises 2060 edges after the edge sampling start.
- hub_addr is only changed in kLatch, while hub_oe_n=1, and holds its value in kIdle.
- Exactly 64 hub_clk rising edges and 1 hub_lat pulse per plane.
- A start asserted on the cycle is_idle is first 1 is accepted (back-to-back rows).

Test Plan:
- Reset → hold reset=0 for 3 cycles with start toggling → is_idle=1, hub_oe_n=1, hub_lat=0, hub_clk=0, hub_addr=0, read_address=0 throughout; no start accepted.
- Full-red upper row → all words 0xFF0000_000000, bank=0, y=5 → hub_r0=1 at every hub_clk rise, other colours 0. 64 clk rises and 1 lat per plane, 8 lat pulses total. hub_oe_n low runs of 4, 8, 16, …, 512. hub_addr=5 from first latch. is_idle after 2060 cycles.
- Bit mapping → column 3 lower blue=0x05, all else 0 → hub_b1=1 only at column 3 of planes 0 and 2; all other colour samples 0.
- Bank/row → bank=1, y=31 → read_address ranges 64..127, first address 64; hub_addr=31 after first kLatch and never changes while hub_oe_n=0.
- Handshake → start again 100 cycles into a row → ignored, row still 2060 cycles. start on the first is_idle cycle → second row accepted, is_idle=0 on the next edge.
- Reset mid-row → reset=0 during kDisplay of plane 5 → next edge hub_oe_n=1, is_idle=1, hub_lat=0. A new start then behaves as a fresh row from plane 0.

Source files
------------

// File: rtl/hub75_row_driver.sv
// HUB-75 row-pair driver: shifts one line-buffer row per bit plane (LSB first),
// latches it and holds output-enable for a binary-weighted time per plane.
module hub75_row_driver #(
  parameter int column_count        = 64,
  parameter int color_depth         = 8,
  parameter int address_width       = 7,
  parameter int data_width          = 48,
  parameter int row_width           = 5,
  parameter int base_on_time        = 4,
  parameter int display_count_width = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [row_width-1:0]     y,
  input  logic                     bank,
  output logic                     is_idle,
  output logic [address_width-1:0] read_address,
  input  logic [data_width-1:0]    read_data,
  output logic                     hub_r0,
  output logic                     hub_g0,
  output logic                     hub_b0,
  output logic                     hub_r1,
  output logic                     hub_g1,
  output logic                     hub_b1,
  output logic                     hub_clk,
  output logic                     hub_lat,
  output logic                     hub_oe_n,
  output logic [row_width-1:0]     hub_addr
);

  localparam int column_width = address_width - 1;
  localparam int plane_width  = $clog2(color_depth);
  localparam logic [column_width-1:0] last_column = column_width'(column_count - 1);
  localparam logic [plane_width-1:0]  last_plane  = plane_width'(color_depth - 1);

  typedef enum logic [2:0] {
    kIdle,
    kFetch,
    kShiftLow,
    kShiftHigh,
    kLatch,
    kDisplay
  } state_t;

  state_t                         state;
  logic [column_width-1:0]        column;
  logic [plane_width-1:0]         plane;
  logic [row_width-1:0]           y_q;
  logic                           bank_q;
  logic [display_count_width-1:0] display_count;
  logic [data_width-1:0]          plane_bits;
  logic [column_width-1:0]        load_column;

  // Shifting the word right by the plane index puts bit b of every channel
  // at the channel's base position.
  assign plane_bits  = read_data >> plane;
  assign load_column = (state == kShiftHigh) ? column + column_width'(1) : column;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= kIdle;
      is_idle       <= 1'b1;
      hub_oe_n      <= 1'b1;
      hub_lat       <= 1'b0;
      hub_clk       <= 1'b0;
      hub_r0        <= 1'b0;
      hub_g0        <= 1'b0;
      hub_b0        <= 1'b0;
      hub_r1        <= 1'b0;
      hub_g1        <= 1'b0;
      hub_b1        <= 1'b0;
      hub_addr      <= '0;
      read_address  <= '0;
      plane         <= '0;
      column        <= '0;
      display_count <= '0;
    end else begin
      case (state)
        kIdle: begin
          is_idle  <= 1'b1;
          hub_oe_n <= 1'b1;
          if (start) begin
            y_q          <= y;
            bank_q       <= bank;
            plane        <= '0;
            column       <= '0;
            read_address <= {bank, {column_width{1'b0}}};
            is_idle      <= 1'b0;
            state        <= kFetch;
          end
        end
        kShiftLow: begin
          hub_clk <= 1'b1;
          state   <= kShiftHigh;
        end
        kFetch, kShiftHigh: begin
          if (state == kShiftHigh && column == last_column) begin
            hub_clk       <= 1'b0;
            hub_lat       <= 1'b1;
            hub_addr      <= y_q;
            display_count <= display_count_width'(base_on_time) << plane;
            state         <= kLatch;
          end else begin
            // Present the next column's address while this column is shifted.
            hub_r0       <= plane_bits[5*color_depth];
            hub_g0       <= plane_bits[4*color_depth];
            hub_b0       <= plane_bits[3*color_depth];
            hub_r1       <= plane_bits[2*color_depth];
            hub_g1       <= plane_bits[1*color_depth];
            hub_b1       <= plane_bits[0];
            hub_clk      <= 1'b0;
            column       <= load_column;
            read_address <= {bank_q, load_column + column_width'(1)};
            state        <= kShiftLow;
          end
        end
        kLatch: begin
          hub_lat  <= 1'b0;
          hub_oe_n <= 1'b0;
          state    <= kDisplay;
        end
        kDisplay: begin
          if (display_count == display_count_width'(1)) begin
            hub_oe_n <= 1'b1;
            if (plane == last_plane) begin
              is_idle <= 1'b1;
              state   <= kIdle;
            end else begin
              plane        <= plane + plane_width'(1);
              column       <= '0;
              read_address <= {bank_q, {column_width{1'b0}}};
              state        <= kFetch;
            end
          end else begin
            display_count <= display_count - display_count_width'(1);
          end
        end
        default: state <= kIdle;
      endcase
    end
  end

endmodule
